// File: rtl/dual_port_ram_if.sv
// Bus bundle for the simple dual-port RAM: one write port and one read port
// sharing a single global enable.
interface dual_port_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              enb;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;

  modport master (
    output enb, wr, rd, w_addr, r_addr, w_data,
    input  r_data
  );

  modport slave (
    input  enb, wr, rd, w_addr, r_addr, w_data,
    output r_data
  );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM with registered, write-first read data.
// Reset clears every word and the read register immediately.
module dual_port_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  dual_port_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] r_data_q;
  logic [DATA_W-1:0] r_data_d;

  // NOTE: hold-by-default assignments first keep this block free of latches.
  always_comb begin
    mem_d    = mem_q;
    r_data_d = r_data_q;
    if (bus.enb) begin
      if (bus.wr) begin
        mem_d[bus.w_addr] = bus.w_data;
      end
      if (bus.rd) begin
        // Same-address collision returns the incoming word rather than stale storage.
        if (bus.wr && (bus.w_addr == bus.r_addr)) begin
          r_data_d = bus.w_data;
        end else begin
          r_data_d = mem_q[bus.r_addr];
        end
      end
    end
  end

  // NOTE: the storage must clear on reset, so it is built from resettable
  // flops rather than a RAM macro; state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      r_data_q <= '0;
    end else begin
      mem_q    <= mem_d;
      r_data_q <= r_data_d;
    end
  end

  assign bus.r_data = r_data_q;
endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: directed vector table, reset corner
// cases, and randomized traffic against a write-then-read array model.
module tb_dual_port_ram;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic clk;
  logic rst;

  dual_port_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a write-first RAM is "apply the write, then read the array".
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] ref_r;

  typedef struct {
    string             name;
    logic              enb;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic w, input logic r,
                       input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra,
                       input logic [DATA_W-1:0] wd);
    bus.enb    = e;
    bus.wr     = w;
    bus.rd     = r;
    bus.w_addr = wa;
    bus.r_addr = ra;
    bus.w_data = wd;
  endtask

  // One clock cycle: drive on the falling edge, update the model at the
  // rising edge, and leave time 1 unit past the edge for sampling.
  task automatic step(input logic e, input logic w, input logic r,
                      input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra,
                      input logic [DATA_W-1:0] wd);
    @(negedge clk);
    drive(e, w, r, wa, ra, wd);
    @(posedge clk);
    if (e) begin
      if (w) ref_mem[wa] = wd;
      if (r) ref_r = ref_mem[ra];
    end
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_r = '0;
  endtask

  initial begin
    vecs[0]  = '{"wr3",            1, 1, 0, 4'd3,  4'd0,  8'hA5, 8'h00};
    vecs[1]  = '{"rd3",            1, 0, 1, 4'd0,  4'd3,  8'h00, 8'hA5};
    vecs[2]  = '{"bypass7",        1, 1, 1, 4'd7,  4'd7,  8'h3C, 8'h3C};
    vecs[3]  = '{"rd7",            1, 0, 1, 4'd0,  4'd7,  8'h00, 8'h3C};
    vecs[4]  = '{"enb0_hold",      0, 1, 1, 4'd3,  4'd3,  8'hFF, 8'h3C};
    vecs[5]  = '{"rd3_after_enb0", 1, 0, 1, 4'd0,  4'd3,  8'h00, 8'hA5};
    vecs[6]  = '{"wr0",            1, 1, 0, 4'd0,  4'd0,  8'h11, 8'hA5};
    vecs[7]  = '{"wr15",           1, 1, 0, 4'd15, 4'd0,  8'hEE, 8'hA5};
    vecs[8]  = '{"rd0",            1, 0, 1, 4'd0,  4'd0,  8'h00, 8'h11};
    vecs[9]  = '{"rd15",           1, 0, 1, 4'd0,  4'd15, 8'h00, 8'hEE};
    vecs[10] = '{"wr5_rd15",       1, 1, 1, 4'd5,  4'd15, 8'h5A, 8'hEE};
    vecs[11] = '{"rd5",            1, 0, 1, 4'd0,  4'd5,  8'h00, 8'h5A};
    vecs[12] = '{"wr5_no_rd_hold", 1, 1, 0, 4'd5,  4'd5,  8'h77, 8'h5A};
    vecs[13] = '{"rd5_new",        1, 0, 1, 4'd0,  4'd5,  8'h00, 8'h77};

    drive(0, 0, 0, '0, '0, '0);
    clear_model();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check("reset_r_data", bus.r_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].enb, vecs[i].wr, vecs[i].rd, vecs[i].wa, vecs[i].ra, vecs[i].wd);
      check(vecs[i].name, bus.r_data, vecs[i].exp);
      check({vecs[i].name, "_model"}, bus.r_data, ref_r);
    end

    // Reset between edges while a write to address 2 is pending.
    @(negedge clk);
    drive(1, 1, 0, 4'd2, 4'd0, 8'h99);
    #2 rst = 1'b0;
    #1 check("midop_reset_immediate", bus.r_data, 8'h00);
    @(posedge clk);
    #1 check("midop_reset_held", bus.r_data, 8'h00);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0);
    rst = 1'b1;
    clear_model();
    for (int a = 0; a < DEPTH; a++) begin
      step(1, 0, 1, '0, a[ADDR_W-1:0], '0);
      check($sformatf("mem_zero_%0d", a), bus.r_data, 8'h00);
    end

    // Randomized traffic against the model, with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      logic              e, w, r;
      logic [ADDR_W-1:0] wa, ra;
      logic [DATA_W-1:0] wd;
      e  = ($urandom_range(0, 7) != 0);
      w  = $urandom_range(0, 1) == 1;
      r  = $urandom_range(0, 1) == 1;
      wa = ADDR_W'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom);
      wd = DATA_W'($urandom);
      step(e, w, r, wa, ra, wd);
      check($sformatf("rand_%0d", n), bus.r_data, ref_r);
    end

    for (int a = 0; a < DEPTH; a++) begin
      step(1, 0, 1, '0, a[ADDR_W-1:0], '0);
      check($sformatf("final_rd_%0d", a), bus.r_data, ref_mem[a]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
